collatz_call_arbiter: RTL
=========================

Name: collatz_call_arbiter

Overview:
- Shares one sum_collatz_top accelerator instance between NUM_REQ independent requesters.
- Each requester offers a 32-bit argument n over a valid/ready handshake.
- The arbiter grants requesters round-robin, sequences the accelerator's start/ready/finish protocol, and captures return_val.
- It returns the result, tagged with the requester index, on a single valid/ready response channel.
- It sits between the requester fabric and the accelerator and replaces the testbench-driven start/finish sequencing.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of the requester index; must equal ceil(log2(NUM_REQ)).
- DATA_W, 32, width of the argument and the result.
- TIMEOUT, 1023, maximum cycles in WAIT before the call is aborted; 0 disables the timeout.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_arg  in  NUM_REQ*DATA_W  per-requester argument n; requester i occupies bits [i*DATA_W +: DATA_W].
- req_ready  out  NUM_REQ  one-hot grant; a request is accepted when req_valid[i] & req_ready[i].
- resp_valid  out  1  a result is available.
- resp_ready  in  1  the consumer accepts the result.
- resp_id  out  ID_W  index of the requester that owns the result.
- resp_data  out  DATA_W  captured return_val; 0 on timeout.
- resp_err  out  1  the call timed out.
- accel_start  out  1  drives the accelerator's start input.
- accel_ready  in  1  the accelerator's ready output.
- accel_finish  in  1  the accelerator's finish output (single-cycle pulse).
- accel_n  out  DATA_W  drives the accelerator's n input.
- accel_return_val  in  DATA_W  the accelerator's return_val output.
- busy  out  1  the arbiter is in any state other than IDLE.
- spurious_finish  out  1  sticky flag: accel_finish was seen outside WAIT.

Behaviour:
- Reset values (reset low, asynchronous):
  - State = IDLE; round-robin pointer = 0.
  - All outputs 0: accel_start, accel_n, resp_*, req_ready, busy, spurious_finish.
- Reset deasserts synchronously with respect to internal use; sequential logic runs from the first rising edge after deassertion.
- IDLE:
  - req_ready is a combinational function of state, req_valid and the pointer.
  - Grant goes to the first requester with req_valid high, searching from the pointer upward and wrapping modulo NUM_REQ.
  - On a grant edge: latch req_arg slice to accel_n, latch the index to the internal id, set pointer = granted index + 1 (wrapping), go to ISSUE.
  - If no req_valid is high, remain in IDLE with req_ready = 0.
- ISSUE:
  - accel_start = 1 (registered) and accel_n held.
  - Call is accepted on the edge where accel_start & accel_ready; then accel_start is 0 from the next cycle and the state goes to WAIT.
  - accel_start stays high for as long as accel_ready is low.
- WAIT:
  - A cycle counter increments every cycle.
  - On accel_finish: capture accel_return_val into resp_data, resp_err = 0, go to RESP.
  - If TIMEOUT != 0 and the counter reaches TIMEOUT without finish: resp_data = 0, resp_err = 1, go to RESP.
  - accel_n is held through WAIT.
- RESP:
  - resp_valid = 1; resp_id, resp_data and resp_err are stable until the handshake.
  - On resp_valid & resp_ready: go to IDLE and drop resp_valid the next cycle.
- Latency: request accept at edge 0 → accel_start high in cycle 1 → finish at edge k → resp_valid high in cycle k+1.
- Back-to-back calls: after a RESP handshake, IDLE can grant in the following cycle. Minimum spacing is 1 idle cycle.
- accel_finish outside WAIT, including in the same cycle as ISSUE acceptance, is ignored for data and sets spurious_finish. The flag clears only on reset.
- req_ready is never asserted outside IDLE. Changes to req_valid or req_arg after the grant have no effect on the current call.
- Reset mid-call aborts with no response. The arbiter does not reset the accelerator; the system reset must cover both.

Test Plan:
- Single call: model returns n+1000 after 7 cycles. Requester 0 sends n=27 → accel_start pulses 1 cycle with accel_n=27; resp_valid rises 8 cycles after start acceptance with resp_id=0, resp_data=1027, resp_err=0.
- Fairness: all 4 requesters hold valid continuously with args 1,2,3,4 → grant order 0,1,2,3,0; resp_data 1001,1002,1003,1004,1001.
- Stalls: accel_ready held low for 5 cycles in ISSUE, resp_ready low for 3 cycles in RESP → accel_start stays high 6 cycles; resp fields stay constant; exactly one grant occurs per call.
- Timeout: TIMEOUT=20 and the model never asserts finish → resp_err=1 and resp_data=0 after 20 WAIT cycles; the next request is served normally.
- Spurious finish: accel_finish pulsed while IDLE → spurious_finish=1 and stays set; no response is generated.
- Async reset: reset driven low during WAIT between clock edges → all outputs are 0 immediately; after release, a new request to requester 2 is granted first when the pointer is 0.

Source files
------------

// File: rtl/collatz_call_arbiter.sv
// Purpose : shares one sum_collatz_top accelerator between NUM_REQ requesters, round-robin.
// Latency : grant edge -> accel_start next cycle; accel_finish at edge k -> resp_valid in cycle k+1.
// Backpr. : req_ready only in IDLE; accel_start held until accel_ready; resp held until resp_ready.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-low reset
//   req_valid/ready/arg   per-requester valid/ready request channel, arg i at [i*DATA_W +: DATA_W]
//   resp_valid/ready      single response channel carrying resp_id, resp_data, resp_err
//   accel_*               start/ready/finish handshake, n and return_val of the shared accelerator
//   busy                  high in any state other than IDLE
//   spurious_finish       sticky: accel_finish observed outside WAIT
//
// Reset release is expected to be synchronised to clk at system level; the
// accelerator itself is not reset from here.
module collatz_call_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1023
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_arg,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [ID_W-1:0]           resp_id,
  output logic [DATA_W-1:0]         resp_data,
  output logic                      resp_err,
  output logic                      accel_start,
  input  logic                      accel_ready,
  input  logic                      accel_finish,
  output logic [DATA_W-1:0]         accel_n,
  input  logic [DATA_W-1:0]         accel_return_val,
  output logic                      busy,
  output logic                      spurious_finish
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // Counter only needs to reach TIMEOUT-1; one bit is enough when disabled.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  state_t            state;
  logic [ID_W-1:0]   ptr;
  logic [CNT_W-1:0]  cnt;

  logic              found;
  logic [ID_W-1:0]   gnt_idx;
  logic [ID_W-1:0]   nxt_ptr;
  logic [ID_W:0]     cand;

  // Round-robin search: first valid requester at or above ptr, wrapping.
  // cand carries one extra bit so ptr+k never overflows before the wrap.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr} + (ID_W + 1)'(k);
      if (cand >= (ID_W + 1)'(NUM_REQ)) begin
        cand = cand - (ID_W + 1)'(NUM_REQ);
      end
      if (!found && req_valid[cand[ID_W-1:0]]) begin
        found   = 1'b1;
        gnt_idx = cand[ID_W-1:0];
      end
    end
  end

  assign nxt_ptr = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;

  // Gated by reset so the grant is 0 while reset is held, not only after it.
  always_comb begin
    req_ready = '0;
    if (reset && state == ST_IDLE && found) begin
      req_ready[gnt_idx] = 1'b1;
    end
  end

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= ST_IDLE;
      ptr             <= '0;
      cnt             <= '0;
      accel_start     <= 1'b0;
      accel_n         <= '0;
      resp_valid      <= 1'b0;
      resp_id         <= '0;
      resp_data       <= '0;
      resp_err        <= 1'b0;
      spurious_finish <= 1'b0;
    end else begin
      // A finish outside WAIT never touches data, it only raises the flag.
      if (accel_finish && state != ST_WAIT) begin
        spurious_finish <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (found) begin
            accel_n     <= req_arg[gnt_idx*DATA_W +: DATA_W];
            resp_id     <= gnt_idx;
            ptr         <= nxt_ptr;
            accel_start <= 1'b1;
            state       <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          if (accel_ready) begin
            accel_start <= 1'b0;
            cnt         <= '0;
            state       <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (accel_finish) begin
            resp_data  <= accel_return_val;
            resp_err   <= 1'b0;
            resp_valid <= 1'b1;
            state      <= ST_RESP;
          end else if (TIMEOUT != 0 && cnt == CNT_LAST) begin
            // cnt counts WAIT cycles from 0, so this fires after TIMEOUT of them.
            resp_data  <= '0;
            resp_err   <= 1'b1;
            resp_valid <= 1'b1;
            state      <= ST_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
